// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the async FIFO write port among NUM_REQ producers in the write
//   clock domain. Round-robin arbitration with packet lock: once granted, a
//   requester owns the port until it transfers a word flagged req_last.
//   All producers are throttled while the FIFO reports wfull.
//
//   Optional feature macro: FIFO_WR_ARB_TIMEOUT_EN
//     When defined, an owner that presents no valid word for TIMEOUT_CYCLES
//     consecutive non-full cycles loses the lock, and timeout pulses once.
//     When undefined, the lock is held until req_last and timeout is 0.
//
// Ports
//   wclk      : write-domain clock
//   wrst      : synchronous active-high reset
//   req_valid : per-requester word valid
//   req_last  : per-requester end-of-packet, qualified by req_valid
//   req_data  : packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready : per-requester accept, at most one bit set
//   wfull     : FIFO full flag from the write-pointer block
//   winc      : FIFO write strobe
//   wdata     : FIFO write data
//   grant_id  : current owner index, meaningful while busy
//   busy      : high while a requester holds the lock
//   timeout   : one-cycle pulse on a forced lock release
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy,
   output logic                          timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   state_t              state_q;
   logic [ID_WIDTH-1:0] rr_ptr_q;
   logic [ID_WIDTH-1:0] grant_q;
   logic                timeout_q;

   logic                hit;
   logic [ID_WIDTH-1:0] winner;
   logic [ID_WIDTH-1:0] rr_ptr_d;
   logic                owner_valid;
   logic                owner_last;
   logic                expire;

   // Round-robin search: scan from the highest offset down so the lowest
   // offset from rr_ptr_q (the first set bit ascending) is written last.
   always_comb begin
      int idx;
      hit    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (req_valid[idx]) begin
            hit    = 1'b1;
            winner = idx[ID_WIDTH-1:0];
         end
      end
   end

   assign owner_valid = req_valid[grant_q];
   assign owner_last  = req_last[grant_q];
   assign rr_ptr_d    = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // Write path is purely combinational from the registered owner.
   assign winc = (state_q == LOCK) & owner_valid & ~wfull;

   always_comb begin
      req_ready = '0;
      wdata     = '0;
      if (state_q == LOCK) begin
         req_ready[grant_q] = ~wfull;
         wdata              = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
      end
   end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt_q;

   // Release fires on the cycle that would make the idle count reach the limit.
   assign expire = (state_q == LOCK) & ~owner_valid & ~wfull
                   & (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts consecutive owner-silent cycles; full cycles hold the count.
   always_ff @(posedge wclk) begin
      if (wrst || state_q != LOCK || owner_valid || expire) begin
         idle_cnt_q <= '0;
      end else if (!wfull) begin
         idle_cnt_q <= idle_cnt_q + 1'b1;
      end
   end
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hit) begin
                  grant_q <= winner;
                  state_q <= LOCK;
               end
            end
            LOCK: begin
               if ((winc && owner_last) || expire) begin
                  state_q   <= IDLE;
                  rr_ptr_q  <= rr_ptr_d;
                  timeout_q <= expire;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_id = grant_q;
   assign busy     = (state_q == LOCK);
   assign timeout  = timeout_q;

endmodule
